vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Produces h/v counters, sync, blank and
//  frame/line markers for any mode described by a timing_cfg_t. Runtime mode switch
//  via valid/ready handshake, applied only at a frame boundary. Pixel-clock enable
//  supports sub-rate pixel clocks. Sits at the head of the draw pipeline (bg/rect/char).
// PARAMETERS
//  H_W       11                width of hcount / horizontal cfg fields
//  V_W       10                width of vcount / vertical cfg fields
//  DEF_CFG   vga_pkg::CFG_800x600  mode active out of reset (800x600@60, 40 MHz)
//  HS_POL    1'b0              active level of hsync (0 = active-low)
//  VS_POL    1'b0              active level of vsync
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous reset, active-low
//  pix_en       in   1    pixel step enable; counters advance only when 1
//  cfg_valid    in   1    new mode offered
//  cfg_ready    out  1    generator can accept a new mode
//  cfg          in   struct  timing_cfg_t {h_pix,h_total,h_sync_start,h_sync_time,
//                                        v_pix,v_total,v_sync_start,v_sync_time}
//  cfg_err      out  1    1-clk pulse: offered cfg rejected as illegal
//  hcount       out  H_W  current column, 0..h_total-1
//  vcount       out  V_W  current line, 0..v_total-1
//  hsync        out  1    horizontal sync (level per HS_POL)
//  vsync        out  1    vertical sync (level per VS_POL)
//  hblnk        out  1    hcount >= h_pix
//  vblnk        out  1    vcount >= v_pix
//  line_start   out  1    1-clk pulse when hcount becomes 0
//  frame_start  out  1    1-clk pulse when (hcount,vcount) becomes (0,0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): hcount=vcount=0, hblnk=vblnk=0, hsync=~HS_POL, vsync=~VS_POL,
//    line_start=frame_start=cfg_err=0, cfg_ready=1, active cfg=DEF_CFG, pending cfg dropped.
//  - All outputs registered; sync/blank decoded from the next counter value so every
//    output is aligned with hcount/vcount in the same cycle (zero relative skew).
//  - Step (pix_en=1): hcount==h_total-1 -> hcount=0, vcount+1 (vcount==v_total-1 -> 0);
//    else hcount+1. pix_en=0: all state and outputs hold; pulses are 0.
//  - hsync active iff h_sync_start <= hcount < h_sync_start+h_sync_time; vsync likewise
//    on vcount. Comparisons unsigned, sums computed at H_W+1 / V_W+1 bits.
//  - Handshake FSM states IDLE (cfg_ready=1) / PENDING (cfg_ready=0).
//    IDLE: cfg_valid=1 -> check legality: h_pix<h_total, h_sync_start+h_sync_time<=h_total,
//    h_sync_time>0, same for v. Legal -> latch into pending, go PENDING. Illegal -> cfg_err=1
//    next clk, stay IDLE.
//    PENDING: on the step that wraps to (0,0) the pending cfg becomes active; counters are
//    0,0 and outputs decoded with the new cfg; frame_start=1; next clk -> IDLE, cfg_ready=1.
//  - Accept coinciding with a wrap step: the new cfg waits for the following wrap.
//  - Active cfg never changes mid-frame; counters never exceed new totals after switch.
//  - Reset mid-frame or mid-PENDING: immediate return to reset state, DEF_CFG active.
// STRUCTURE
//  - vga_pkg: timing_cfg_t (packed struct), CFG_800x600 constant (800/1056/840/128,
//    600/628/601/4), H_W/V_W defaults.
//  - Sub-module vga_axis_cnt (width, pol params): one counter + sync/blank decode per
//    axis; instantiated twice, vertical instance stepped by horizontal wrap.
//  - Top holds handshake FSM, pending/active cfg registers, pulse generation.
// TESTING
//  - Reset: hold rst_n=0 -> all outputs at reset values, cfg_ready=1, hsync=vsync=1.
//  - Default mode, pix_en=1: hsync low for hcount 840..967 (128 clk); vsync low vcount
//    601..604; frame_start period 663168 clk; hblnk for hcount 800..1055.
//  - pix_en=1 every 2nd clk: frame_start period 1326336 clk; outputs frozen when pix_en=0.
//  - Mid-frame cfg 16x8 (h_total 20, hs 17/2, v_total 12, vs 9/1): cfg_ready drops next
//    clk, old timing until wrap, then hcount wraps at 19, vcount at 11; cfg_ready=1 after.
//  - Illegal cfg (h_sync_start=1050, h_sync_time=10, h_total 1056) -> cfg_err pulse,
//    cfg_ready stays 1, timing unchanged.
//  - rst_n pulse at hcount=500 while PENDING -> counters 0, DEF_CFG, pending discarded.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster timing generator.
//   timing_cfg_t : one video mode (horizontal and vertical geometry)
//   CFG_800x600  : 800x600@60 (40 MHz pixel clock), the power-up mode
//   cfg_legal    : rejects modes the counters cannot run correctly
package vga_pkg;

    localparam int unsigned CFG_H_W = 11;
    localparam int unsigned CFG_V_W = 10;

    typedef struct packed {
        logic [CFG_H_W-1:0] h_pix;
        logic [CFG_H_W-1:0] h_total;
        logic [CFG_H_W-1:0] h_sync_start;
        logic [CFG_H_W-1:0] h_sync_time;
        logic [CFG_V_W-1:0] v_pix;
        logic [CFG_V_W-1:0] v_total;
        logic [CFG_V_W-1:0] v_sync_start;
        logic [CFG_V_W-1:0] v_sync_time;
    } timing_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } cfg_state_e;

    localparam timing_cfg_t CFG_800x600 = '{
        h_pix:        11'd800,
        h_total:      11'd1056,
        h_sync_start: 11'd840,
        h_sync_time:  11'd128,
        v_pix:        10'd600,
        v_total:      10'd628,
        v_sync_start: 10'd601,
        v_sync_time:  10'd4
    };

    // Visible area inside the total, sync pulse non-empty and ending inside the total.
    function automatic logic cfg_legal(timing_cfg_t c);
        logic h_ok;
        logic v_ok;
        h_ok = (c.h_pix < c.h_total) &&
               (({1'b0, c.h_sync_start} + {1'b0, c.h_sync_time}) <= {1'b0, c.h_total}) &&
               (c.h_sync_time != '0);
        v_ok = (c.v_pix < c.v_total) &&
               (({1'b0, c.v_sync_start} + {1'b0, c.v_sync_time}) <= {1'b0, c.v_total}) &&
               (c.v_sync_time != '0);
        return h_ok && v_ok;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus sync/blank decode.
//   step           : advance the counter (wraps at total-1)
//   total          : length of the axis in the currently running mode
//   dec_*          : geometry used to decode the value being loaded
//   count/sync/blnk: registered, mutually aligned outputs
//   wrap_c         : combinational, count is on its last position
module vga_axis_cnt #(
    parameter int unsigned W   = 11,
    parameter logic        POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic [W-1:0] total,
    input  logic [W-1:0] dec_pix,
    input  logic [W-1:0] dec_sync_start,
    input  logic [W-1:0] dec_sync_time,
    output logic [W-1:0] count,
    output logic         sync,
    output logic         blnk,
    output logic         wrap_c
);

    logic [W-1:0] cnt_nxt;
    logic [W:0]   sync_end;
    logic         in_sync;

    // Decode is done on the next value so sync/blank land together with count.
    always_comb begin
        wrap_c   = (count == (total - W'(1)));
        cnt_nxt  = wrap_c ? '0 : (count + W'(1));
        sync_end = {1'b0, dec_sync_start} + {1'b0, dec_sync_time};
        in_sync  = (cnt_nxt >= dec_sync_start) && ({1'b0, cnt_nxt} < sync_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= ~POL;
            blnk  <= 1'b0;
        end else if (step) begin
            count <= cnt_nxt;
            sync  <= in_sync ? POL : ~POL;
            blnk  <= (cnt_nxt >= dec_pix);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with runtime mode switch.
//   pix_en              : pixel step enable
//   cfg_valid/cfg_ready : offer of a new mode; applied at the next (0,0) wrap
//   cfg                 : offered mode
//   cfg_err             : 1-clk pulse, offered mode rejected
//   hcount/vcount       : raster position
//   hsync/vsync         : sync, active level HS_POL/VS_POL
//   hblnk/vblnk         : outside the visible area
//   line_start          : pulse when hcount becomes 0
//   frame_start         : pulse when (hcount,vcount) becomes (0,0)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_W     = CFG_H_W,
    parameter int unsigned V_W     = CFG_V_W,
    parameter timing_cfg_t DEF_CFG = CFG_800x600,
    parameter logic        HS_POL  = 1'b0,
    parameter logic        VS_POL  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  timing_cfg_t    cfg,
    output logic           cfg_err,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           hblnk,
    output logic           vblnk,
    output logic           line_start,
    output logic           frame_start
);

    cfg_state_e  state;
    cfg_state_e  state_nxt;
    timing_cfg_t act_cfg;
    timing_cfg_t pend_cfg;
    timing_cfg_t dec_cfg;
    logic        load_pend;
    logic        switch_c;
    logic        err_nxt;
    logic        h_wrap_c;
    logic        v_wrap_c;
    logic        v_step_c;
    logic        frame_step_c;

    assign v_step_c     = pix_en & h_wrap_c;
    assign frame_step_c = v_step_c & v_wrap_c;

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept/reject offers; swap in the pending mode on the step that lands on (0,0).
    always_comb begin
        state_nxt = state;
        load_pend = 1'b0;
        err_nxt   = 1'b0;
        switch_c  = 1'b0;
        dec_cfg   = act_cfg;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal(cfg)) begin
                        load_pend = 1'b1;
                        state_nxt = ST_PENDING;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_step_c) begin
                    switch_c  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (switch_c) begin
            dec_cfg = pend_cfg;
        end
    end

    // Mode registers, handshake outputs and position pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cfg     <= DEF_CFG;
            pend_cfg    <= '0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (switch_c) begin
                act_cfg <= pend_cfg;
            end
            if (load_pend) begin
                pend_cfg <= cfg;
            end
            cfg_ready   <= (state_nxt == ST_IDLE);
            cfg_err     <= err_nxt;
            line_start  <= v_step_c;
            frame_start <= frame_step_c;
        end
    end

    // Wrap detection uses the running mode; decode of the loaded value uses the mode
    // that will be active after this step.
    vga_axis_cnt #(
        .W   (H_W),
        .POL (HS_POL)
    ) u_h_axis (
        .clk            (clk),
        .rst_n          (rst_n),
        .step           (pix_en),
        .total          (H_W'(act_cfg.h_total)),
        .dec_pix        (H_W'(dec_cfg.h_pix)),
        .dec_sync_start (H_W'(dec_cfg.h_sync_start)),
        .dec_sync_time  (H_W'(dec_cfg.h_sync_time)),
        .count          (hcount),
        .sync           (hsync),
        .blnk           (hblnk),
        .wrap_c         (h_wrap_c)
    );

    vga_axis_cnt #(
        .W   (V_W),
        .POL (VS_POL)
    ) u_v_axis (
        .clk            (clk),
        .rst_n          (rst_n),
        .step           (v_step_c),
        .total          (V_W'(act_cfg.v_total)),
        .dec_pix        (V_W'(dec_cfg.v_pix)),
        .dec_sync_start (V_W'(dec_cfg.v_sync_start)),
        .dec_sync_time  (V_W'(dec_cfg.v_sync_time)),
        .count          (vcount),
        .sync           (vsync),
        .blnk           (vblnk),
        .wrap_c         (v_wrap_c)
    );

endmodule
